// File: rtl/mul_ctrl_pkg.sv
// Shared encodings, FSM states and sign/magnitude helpers for the RV32M multiply front end.
package mul_ctrl_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    localparam int unsigned DEF_FLUSH_CYCLES = 34;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    function automatic logic op_s1(input logic [1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic op_s2(input logic [1:0] op);
        return (op == OP_MULH);
    endfunction

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic s);
        return (s && x[31]) ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x, input logic n);
        return n ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/mul32.sv
// Shift-and-add 32x32 unsigned multiplier; iteration count equals the bit length of a.
module mul32 (
    input  logic        clk,
    input  logic        valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ready,
    output logic [63:0] res
);

    logic [31:0] r_a;
    logic [63:0] r_b;
    logic [63:0] r_acc;
    logic        r_busy;

    assign ready = r_busy && (r_a == 32'd0);
    assign res   = r_acc;

    // Datapath has no reset; the controller drains any stale job after reset.
    always_ff @(posedge clk) begin
        if (valid) begin
            r_a    <= a;
            r_b    <= {32'd0, b};
            r_acc  <= 64'd0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_a == 32'd0) begin
                r_busy <= 1'b0;
            end else begin
                if (r_a[0]) begin
                    r_acc <= r_acc + r_b;
                end else begin
                    r_acc <= r_acc;
                end
                r_b <= r_b << 1;
                r_a <= r_a >> 1;
            end
        end else begin
            r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/mul_ctrl.sv
// RV32M multiply front end: decode, sign handling, operand swap, one-entry product cache
// and the control FSM driving mul32.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter bit          CACHE_EN     = 1'b1,
    parameter bit          SWAP_EN      = 1'b1,
    parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] rd,
    output logic        ready,
    output logic        busy
);

    state_t      r_state;
    logic [7:0]  r_flush_cnt;

    logic [1:0]  r_op;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic        r_s1;
    logic        r_s2;
    logic        r_neg;
    logic        r_mul_valid;

    logic        r_c_vld;
    logic [31:0] r_c_rs1;
    logic [31:0] r_c_rs2;
    logic        r_c_s1;
    logic        r_c_s2;
    logic [63:0] r_c_p;

    logic        w_s1_in;
    logic        w_s2_in;
    logic        w_neg_in;
    logic        w_hit;
    logic [31:0] w_hit_rd;

    logic [31:0] w_m1;
    logic [31:0] w_m2;
    logic [31:0] w_mul_a;
    logic [31:0] w_mul_b;
    logic        w_mul_ready;
    logic [63:0] w_mul_res;
    logic [63:0] w_prod;
    logic [31:0] w_res_rd;

    // Decode the incoming request and look it up in the product cache.
    always_comb begin
        w_s1_in  = op_s1(op);
        w_s2_in  = op_s2(op);
        w_neg_in = (w_s1_in & rs1[31]) ^ (w_s2_in & rs2[31]);
        w_hit    = 1'b0;
        if (CACHE_EN && r_c_vld && (rs1 == r_c_rs1) && (rs2 == r_c_rs2)) begin
            // The low half is mode independent, so MUL hits on any entry.
            if (op == OP_MUL) begin
                w_hit = 1'b1;
            end else begin
                w_hit = (w_s1_in == r_c_s1) && (w_s2_in == r_c_s2);
            end
        end else begin
            w_hit = 1'b0;
        end
        w_hit_rd = (op == OP_MUL) ? r_c_p[31:0] : r_c_p[63:32];
    end

    // Magnitudes of the latched operands; the smaller one goes to a to shorten the run.
    always_comb begin
        w_m1 = mag32(r_rs1, r_s1);
        w_m2 = mag32(r_rs2, r_s2);
        if (SWAP_EN && (w_m2 < w_m1)) begin
            w_mul_a = w_m2;
            w_mul_b = w_m1;
        end else begin
            w_mul_a = w_m1;
            w_mul_b = w_m2;
        end
        w_prod   = neg64(w_mul_res, r_neg);
        w_res_rd = (r_op == OP_MUL) ? w_prod[31:0] : w_prod[63:32];
    end

    mul32 u_mul (
        .clk   (clk),
        .valid (r_mul_valid),
        .a     (w_mul_a),
        .b     (w_mul_b),
        .ready (w_mul_ready),
        .res   (w_mul_res)
    );

    // Control FSM with registered outputs and the cache entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= FLUSH;
            r_flush_cnt <= 8'd0;
            r_op        <= 2'b00;
            r_rs1       <= 32'd0;
            r_rs2       <= 32'd0;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_neg       <= 1'b0;
            r_mul_valid <= 1'b0;
            r_c_vld     <= 1'b0;
            r_c_rs1     <= 32'd0;
            r_c_rs2     <= 32'd0;
            r_c_s1      <= 1'b0;
            r_c_s2      <= 1'b0;
            r_c_p       <= 64'd0;
            rd          <= 32'd0;
            ready       <= 1'b0;
            busy        <= 1'b1;
        end else begin
            ready       <= 1'b0;
            r_mul_valid <= 1'b0;
            case (r_state)
                FLUSH: begin
                    // mul32 ready is ignored here: it may be a stale job completing.
                    if (r_flush_cnt == 8'(FLUSH_CYCLES - 1)) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 8'd1;
                    end
                end
                IDLE: begin
                    if (valid) begin
                        r_op  <= op;
                        r_rs1 <= rs1;
                        r_rs2 <= rs2;
                        r_s1  <= w_s1_in;
                        r_s2  <= w_s2_in;
                        r_neg <= w_neg_in;
                        if (w_hit) begin
                            rd    <= w_hit_rd;
                            ready <= 1'b1;
                        end else begin
                            r_state     <= ISSUE;
                            r_mul_valid <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (w_mul_ready) begin
                        rd      <= w_res_rd;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                        r_c_vld <= CACHE_EN;
                        r_c_rs1 <= r_rs1;
                        r_c_rs2 <= r_rs2;
                        r_c_s1  <= r_s1;
                        r_c_s2  <= r_s2;
                        r_c_p   <= w_prod;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                default: begin
                    r_state     <= FLUSH;
                    r_flush_cnt <= 8'd0;
                    busy        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Scoreboard bench for mul_ctrl: directed products, latency, cache hits, reset in WAIT, busy spam.
module tb_mul_ctrl;
    import mul_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    logic        ready;
    logic        busy;

    typedef struct {
        logic [31:0] rd;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_n  = 0;

    bit          bc_vld = 1'b0;
    logic [31:0] bc_rs1 = 32'd0;
    logic [31:0] bc_rs2 = 32'd0;
    bit          bc_s1  = 1'b0;
    bit          bc_s2  = 1'b0;

    mul_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .op    (op),
        .rs1   (rs1),
        .rs2   (rs2),
        .rd    (rd),
        .ready (ready),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_rd(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        logic        s1 = (o == 2'b01) || (o == 2'b10);
        logic        s2 = (o == 2'b01);
        logic [63:0] ea = s1 ? {{32{a[31]}}, a} : {32'd0, a};
        logic [63:0] eb = s2 ? {{32{b[31]}}, b} : {32'd0, b};
        logic [63:0] p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int bitlen(input logic [31:0] x);
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) return i + 1;
        end
        return 0;
    endfunction

    function automatic logic [31:0] absv(input logic [31:0] x, input logic s);
        return (s && x[31]) ? (32'd0 - x) : x;
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        logic        s1 = (o == 2'b01) || (o == 2'b10);
        logic        s2 = (o == 2'b01);
        logic [31:0] m1 = absv(a, s1);
        logic [31:0] m2 = absv(b, s2);
        if (bc_vld && a == bc_rs1 && b == bc_rs2 && (o == 2'b00 || (s1 == bc_s1 && s2 == bc_s2)))
            return 1;
        return 3 + bitlen((m1 < m2) ? m1 : m2);
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc_n++;
        if (ready === 1'b1) begin
            exp_t e;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL spurious_ready: ready=1 rd=%h with %0d pending, required none", rd, sb.size());
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert (rd === e.rd) else begin
                    errors++;
                    $error("FAIL rd_value: got %h required %h", rd, e.rd);
                end
                checks++;
                assert ((cyc_n - e.acc) === e.lat) else begin
                    errors++;
                    $error("FAIL latency: got %0d required %0d", cyc_n - e.acc, e.lat);
                end
            end
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_rd, input int exp_lat);
        exp_t e;
        op    = o;
        rs1   = a;
        rs2   = b;
        valid = 1'b1;
        if (busy === 1'b0) begin
            e.rd  = exp_rd;
            e.acc = cyc_n;
            e.lat = exp_lat;
            sb.push_back(e);
            if (exp_lat != 1) begin
                bc_vld = 1'b1;
                bc_rs1 = a;
                bc_rs2 = b;
                bc_s1  = (o == 2'b01) || (o == 2'b10);
                bc_s2  = (o == 2'b01);
            end
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && sb.size() > 0; n++) tick();
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout: got %0d pending required 0", sb.size());
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_rd, input int exp_lat);
        for (int n = 0; n < 100 && busy !== 1'b0; n++) tick();
        checks++;
        assert (busy === 1'b0) else begin
            errors++;
            $error("FAIL idle_wait: got busy=%b required 0", busy);
        end
        drive(o, a, b, exp_rd, exp_lat);
        tick();
        valid = 1'b0;
        drain();
    endtask

    task automatic flush_check();
        int nb = 0;
        int nz = 0;
        int nr = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) nb++;
            if (rd !== 32'd0) nz++;
            if (ready !== 1'b0) nr++;
            tick();
        end
        checks++;
        assert (nb === 34) else begin
            errors++;
            $error("FAIL flush_len: got %0d busy cycles required 34", nb);
        end
        checks++;
        assert (nz === 0) else begin
            errors++;
            $error("FAIL flush_rd: got %0d nonzero rd cycles required 0", nz);
        end
        checks++;
        assert (nr === 0) else begin
            errors++;
            $error("FAIL flush_ready: got %0d ready cycles required 0", nr);
        end
    endtask

    initial begin
        logic [1:0]  so;
        logic [31:0] sa;
        logic [31:0] sbv;

        reset = 1'b1;
        valid = 1'b0;
        op    = 2'b00;
        rs1   = 32'd0;
        rs2   = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        assert (rd === 32'd0) else begin errors++; $error("FAIL reset_rd: got %h required 0", rd); end
        checks++;
        assert (ready === 1'b0) else begin errors++; $error("FAIL reset_ready: got %b required 0", ready); end
        checks++;
        assert (busy === 1'b1) else begin errors++; $error("FAIL reset_busy: got %b required 1", busy); end
        reset = 1'b0;
        flush_check();

        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        run_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1);
        run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
        run_op(OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 4);
        run_op(OP_MUL,    32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1);
        run_op(OP_MUL,    32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 3);
        run_op(OP_MUL,    32'h0001_0000, 32'h0000_0003, 32'h0003_0000, 5);

        // Reset while the multiply is in flight: result must be dropped.
        for (int n = 0; n < 100 && busy !== 1'b0; n++) tick();
        drive(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        tick();
        valid = 1'b0;
        repeat (10) tick();
        checks++;
        assert (busy === 1'b1) else begin errors++; $error("FAIL wait_busy: got %b required 1", busy); end
        reset = 1'b1;
        sb.delete();
        bc_vld = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        flush_check();
        run_op(OP_MUL, 32'd7, 32'd6, 32'd42, 6);

        // Request every cycle with changing operands; only idle-cycle requests are accepted.
        for (int i = 0; i < 150; i++) begin
            tick();
            so  = 2'($urandom_range(3, 0));
            sa  = (i % 3 == 0) ? 32'($urandom_range(255, 0)) : 32'($urandom);
            sbv = (i % 4 == 1) ? 32'($urandom_range(255, 0)) : 32'($urandom);
            drive(so, sa, sbv, model_rd(so, sa, sbv), model_lat(so, sa, sbv));
        end
        tick();
        valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
